rr_requester: RTL

- Requester-side companion of the 4-way round-robin arbiter.
- Four producer channels each write words into a private FIFO.
- The block drives the arbiter's req[3:0] from FIFO occupancy and consumes the returned one-hot gnt[3:0].
- It streams a burst of up to MAX_BURST words from the granted channel onto a single shared output, then releases req for one cycle so the arbiter rotates.

---
 rtl/rr_pkg.sv | 23 ++
 rtl/rr_req_fifo.sv | 55 +++++
 rtl/rr_requester.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/rr_pkg.sv
// Shared types and helpers for the round-robin arbiter and its requester.
package rr_pkg;

  localparam int NUM_REQ_DEF = 4;

  typedef logic [NUM_REQ_DEF-1:0] req_vec_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BURST   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  function automatic logic onehot_chk(input req_vec_t vec);
    int ones;
    ones = 0;
    for (int i = 0; i < NUM_REQ_DEF; i++) begin
      if (vec[i]) ones++;
    end
    return (ones == 1);
  endfunction

endpackage

// File: rtl/rr_req_fifo.sv
// Single-channel synchronous FIFO used by rr_requester; DEPTH must be a power of two.
module rr_req_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [DW-1:0]          push_data_i,
  input  logic                   pop_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [DW-1:0]          head_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rr_requester.sv
// Requester side of the 4-way round-robin arbiter: per-channel FIFOs, req generation, burst streaming.
// Optional RR_REQUESTER_STATS_EN adds per-channel saturating grant counters on port grant_cnt.
module rr_requester
  import rr_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int DW        = 8,
  parameter int DEPTH     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         in_valid,
  input  logic [NUM_REQ*DW-1:0]      in_data,
  output logic [NUM_REQ-1:0]         in_ready,
  output logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         gnt,
  output logic                       out_valid,
  output logic [DW-1:0]              out_data,
  output logic [$clog2(NUM_REQ)-1:0] out_id,
  input  logic                       out_ready,
  output logic                       err
`ifdef RR_REQUESTER_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]      grant_cnt
`endif
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int BW  = $clog2(MAX_BURST + 1);

  state_e            state_q, state_d;
  logic [IDW-1:0]    cur_q, cur_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic              err_q, err_d;
  logic [NUM_REQ-1:0] req_q, req_d;

  logic [NUM_REQ-1:0] fifo_full, fifo_empty, fifo_pop, push_acc;
  logic [DW-1:0]      fifo_head [NUM_REQ];
  logic [CW-1:0]      fifo_cnt  [NUM_REQ];
  logic               accept;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
    assign fifo_pop[i] = accept && (cur_q == IDW'(i));
    rr_req_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (in_valid[i]),
      .push_data_i(in_data[i*DW +: DW]),
      .pop_i      (fifo_pop[i]),
      .full_o     (fifo_full[i]),
      .empty_o    (fifo_empty[i]),
      .head_o     (fifo_head[i]),
      .count_o    (fifo_cnt[i])
    );
  end

  assign in_ready  = ~fifo_full;
  assign push_acc  = in_valid & in_ready;
  assign out_valid = (state_q == BURST) && gnt[cur_q] && !fifo_empty[cur_q];
  assign out_data  = out_valid ? fifo_head[cur_q] : '0;
  assign out_id    = cur_q;
  assign accept    = out_valid && out_ready;
  assign req       = req_q;
  assign err       = err_q;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    beat_d  = beat_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (onehot_chk(gnt)) begin
          if ((gnt & req_q) != '0) begin
            state_d = BURST;
            beat_d  = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
              if (gnt[i]) cur_d = IDW'(i);
            end
          end
        end else if (gnt != '0) begin
          err_d = 1'b1;
        end
      end
      BURST: begin
        if (!gnt[cur_q]) begin
          err_d   = 1'b1;
          state_d = RELEASE;
        end else if (accept) begin
          beat_d = beat_q + 1'b1;
          // A push landing on the last word keeps the burst going.
          if (beat_q == BW'(MAX_BURST - 1) ||
              (fifo_cnt[cur_q] == CW'(1) && !push_acc[cur_q]))
            state_d = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    for (int i = 0; i < NUM_REQ; i++) begin
      req_d[i] = !fifo_empty[i] && !(state_d == RELEASE && cur_q == IDW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      req_q   <= req_d;
    end
  end

`ifdef RR_REQUESTER_STATS_EN
  logic [15:0] grant_cnt_q [NUM_REQ];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
    end else if (state_q == IDLE && state_d == BURST && grant_cnt_q[cur_d] != 16'hFFFF) begin
      grant_cnt_q[cur_d] <= grant_cnt_q[cur_d] + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_gcnt
    assign grant_cnt[i*16 +: 16] = grant_cnt_q[i];
  end
`endif

endmodule
